// File: rtl/permute_channel_arbiter_if.sv
// Arbiter <-> permute_stage link: the owner's rate block and control copy going out,
// the stage's buffer clears and output write strobe coming back.
interface permute_channel_arbiter_if #(
  parameter int RATE_W = 1344
);
  logic [RATE_W-1:0] rate_input;
  logic [31:0]       output_size;
  logic [1:0]        operation_mode;
  logic              copy_control_regs_en;
  logic              input_buffer_ready;
  logic              last_block_in_buffer;
  logic              output_buffer_ready;
  logic              input_buffer_ready_clr;
  logic              last_block_in_buffer_clr;
  logic              output_buffer_we;

  modport master (
    output rate_input, output_size, operation_mode, copy_control_regs_en,
           input_buffer_ready, last_block_in_buffer, output_buffer_ready,
    input  input_buffer_ready_clr, last_block_in_buffer_clr, output_buffer_we
  );

  modport slave (
    input  rate_input, output_size, operation_mode, copy_control_regs_en,
           input_buffer_ready, last_block_in_buffer, output_buffer_ready,
    output input_buffer_ready_clr, last_block_in_buffer_clr, output_buffer_we
  );
endinterface

// File: rtl/permute_channel_arbiter.sv
// Shares one permute_stage between NUM_CH SHAKE request channels: round-robin grant held
// for a whole message while the stage is sequenced through config copy, absorb and squeeze.
//
// state   | meaning
// IDLE    | no owner; pick next valid channel at or after rr_ptr
// CONFIG  | one cycle, stage latches owner's size/mode, remaining loaded
// ABSORB  | owner's input blocks fed until the last block is cleared
// SQUEEZE | owner's output blocks written until remaining is exhausted
module permute_channel_arbiter #(
  parameter int NUM_CH       = 2,
  parameter int RATE128_BITS = 1344,
  parameter int RATE256_BITS = 1088,
  parameter int RATE_W       = RATE128_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*RATE_W-1:0] ch_rate_input,
  input  logic [NUM_CH*32-1:0]     ch_output_size,
  input  logic [NUM_CH*2-1:0]      ch_operation_mode,
  input  logic [NUM_CH-1:0]        ch_block_valid,
  input  logic [NUM_CH-1:0]        ch_block_last,
  input  logic [NUM_CH-1:0]        ch_out_ready,
  output logic [NUM_CH-1:0]        ch_block_clr,
  output logic [NUM_CH-1:0]        ch_last_clr,
  output logic [NUM_CH-1:0]        ch_out_we,
  output logic [NUM_CH-1:0]        ch_grant,
  permute_channel_arbiter_if.master stage
);
  localparam int          PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] STEP128 = 32'(RATE128_BITS);
  localparam logic [31:0] STEP256 = 32'(RATE256_BITS);

  typedef enum logic [1:0] {IDLE, CONFIG, ABSORB, SQUEEZE} state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]       remaining_q, remaining_d;
  logic              mode128_q, mode128_d;
  logic              cfg_en_q, cfg_en_d;

  logic [RATE_W-1:0] own_rate;
  logic [31:0]       own_size;
  logic [1:0]        own_mode;
  logic [PTR_W-1:0]  own_idx;
  logic [NUM_CH-1:0] pick;
  logic [31:0]       step;

  // Owner muxes are driven from the registered grant only, so they read 0 while idle.
  always_comb begin
    own_rate = '0;
    own_size = '0;
    own_mode = '0;
    own_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q[i]) begin
        own_rate = own_rate | ch_rate_input[i*RATE_W +: RATE_W];
        own_size = own_size | ch_output_size[i*32 +: 32];
        own_mode = own_mode | ch_operation_mode[i*2 +: 2];
        own_idx  = PTR_W'(i);
      end
    end
  end

  // Closest valid channel in circular distance from rr_ptr wins.
  always_comb begin
    int d;
    int best;
    pick = '0;
    d    = 0;
    best = NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      d = i - int'(rr_ptr_q);
      if (d < 0) d = d + NUM_CH;
      if (ch_block_valid[i] && d < best) begin
        best    = d;
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

  assign step = mode128_q ? STEP128 : STEP256;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    remaining_d = remaining_q;
    mode128_d   = mode128_q;
    case (state_q)
      IDLE: begin
        if (|ch_block_valid) begin
          grant_d = pick;
          state_d = CONFIG;
        end
      end
      CONFIG: begin
        remaining_d = (own_size == 32'd0) ? 32'd1 : own_size;
        mode128_d   = (own_mode == 2'b00);
        state_d     = ABSORB;
      end
      ABSORB: begin
        if (stage.last_block_in_buffer_clr) state_d = SQUEEZE;
      end
      SQUEEZE: begin
        if (stage.output_buffer_we) begin
          if (remaining_q <= step) begin
            state_d     = IDLE;
            grant_d     = '0;
            remaining_d = '0;
            rr_ptr_d    = (own_idx == PTR_W'(NUM_CH - 1)) ? '0 : own_idx + 1'b1;
          end else begin
            remaining_d = remaining_q - step;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    cfg_en_d = (state_d == CONFIG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      remaining_q <= '0;
      mode128_q   <= 1'b0;
      cfg_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      remaining_q <= remaining_d;
      mode128_q   <= mode128_d;
      cfg_en_q    <= cfg_en_d;
    end
  end

  // Stage strobes route back to the owner only while their owning state is active.
  assign ch_block_clr = (state_q == ABSORB && stage.input_buffer_ready_clr) ? grant_q : '0;
  assign ch_last_clr  = (state_q == ABSORB && stage.last_block_in_buffer_clr) ? grant_q : '0;
  assign ch_out_we    = (state_q == SQUEEZE && stage.output_buffer_we) ? grant_q : '0;
  assign ch_grant     = grant_q;

  assign stage.rate_input           = own_rate;
  assign stage.output_size          = own_size;
  assign stage.operation_mode       = own_mode;
  assign stage.copy_control_regs_en = cfg_en_q;
  assign stage.input_buffer_ready   = (state_q == ABSORB) && |(ch_block_valid & grant_q);
  assign stage.last_block_in_buffer = (state_q == ABSORB) && |(ch_block_last & grant_q);
  assign stage.output_buffer_ready  = (state_q == SQUEEZE) && |(ch_out_ready & grant_q);
endmodule

// File: tb/tb_permute_channel_arbiter.sv
// Bench for permute_channel_arbiter: plays the channel buffers and the permute_stage,
// predicting owner order and output block counts from round-robin and size/rate arithmetic.
module tb_permute_channel_arbiter;
  localparam int NUM_CH = 2;
  localparam int RATE_W = 1344;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH*RATE_W-1:0] ch_rate_input;
  logic [NUM_CH*32-1:0]     ch_output_size;
  logic [NUM_CH*2-1:0]      ch_operation_mode;
  logic [NUM_CH-1:0]        ch_block_valid;
  logic [NUM_CH-1:0]        ch_block_last;
  logic [NUM_CH-1:0]        ch_out_ready;
  logic [NUM_CH-1:0]        ch_block_clr;
  logic [NUM_CH-1:0]        ch_last_clr;
  logic [NUM_CH-1:0]        ch_out_we;
  logic [NUM_CH-1:0]        ch_grant;

  always #5 clk = ~clk;

  permute_channel_arbiter_if #(.RATE_W(RATE_W)) bus ();

  permute_channel_arbiter #(.NUM_CH(NUM_CH), .RATE_W(RATE_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .ch_rate_input     (ch_rate_input),
    .ch_output_size    (ch_output_size),
    .ch_operation_mode (ch_operation_mode),
    .ch_block_valid    (ch_block_valid),
    .ch_block_last     (ch_block_last),
    .ch_out_ready      (ch_out_ready),
    .ch_block_clr      (ch_block_clr),
    .ch_last_clr       (ch_last_clr),
    .ch_out_we         (ch_out_we),
    .ch_grant          (ch_grant),
    .stage             (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ptr_m = 0;
  logic [31:0]       size_m [NUM_CH];
  logic [1:0]        mode_m [NUM_CH];
  logic [RATE_W-1:0] rate_m [NUM_CH];
  logic [31:0]       size_tab [8] = '{32'd0, 32'd1, 32'd256, 32'd1088, 32'd1089,
                                      32'd1344, 32'd1345, 32'd3000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input int ptr, input logic [NUM_CH-1:0] v);
    for (int k = 0; k < NUM_CH; k++)
      if (v[(ptr + k) % NUM_CH]) return (ptr + k) % NUM_CH;
    return 0;
  endfunction

  function automatic int exp_blocks(input logic [31:0] s, input logic [1:0] m);
    int st;
    st = (m == 2'b00) ? 1344 : 1088;
    if (s == 32'd0) return 1;
    return (int'(s) + st - 1) / st;
  endfunction

  task automatic req(input int c, input logic [31:0] s, input logic [1:0] m);
    logic [RATE_W-1:0] r;
    for (int w = 0; w < RATE_W / 32; w++) r[w*32 +: 32] = $urandom;
    size_m[c] = s;
    mode_m[c] = m;
    rate_m[c] = r;
    ch_rate_input[c*RATE_W +: RATE_W] = r;
    ch_output_size[c*32 +: 32]        = s;
    ch_operation_mode[c*2 +: 2]       = m;
    ch_block_last[c]                  = 1'b0;
    ch_block_valid[c]                 = 1'b1;
  endtask

  task automatic req_rand(input int c);
    logic [31:0] s;
    if ($urandom_range(0, 3) == 0) s = 32'($urandom_range(1, 6000));
    else s = size_tab[$urandom_range(0, 7)];
    req(c, s, 2'($urandom_range(0, 3)));
  endtask

  // Entered at a falling edge with the arbiter idle; returns at the falling edge after release.
  task automatic serve(input int nblk, input bit stall);
    logic [NUM_CH-1:0] oh;
    int own, cyc, pulses, want;
    logic last_b;
    own = model_pick(ptr_m, ch_block_valid);
    oh = '0;
    oh[own] = 1'b1;
    cyc = 0;
    while (ch_grant === '0 && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("grant", 64'(ch_grant), 64'(oh));
    chk("cfg_en", 64'(bus.copy_control_regs_en), 64'd1);
    chk("output_size", 64'(bus.output_size), 64'(size_m[own]));
    chk("operation_mode", 64'(bus.operation_mode), 64'(mode_m[own]));
    n_cmp++;
    assert (bus.rate_input === rate_m[own]) else begin
      n_err++;
      $error("FAIL rate_input: observed %h expected %h", bus.rate_input[63:0], rate_m[own][63:0]);
    end
    bus.output_buffer_we = 1'b1;
    bus.input_buffer_ready_clr = 1'b1;
    bus.last_block_in_buffer_clr = 1'b1;
    #1;
    chk("stray_we", 64'(ch_out_we), 64'd0);
    chk("stray_blk_clr", 64'(ch_block_clr), 64'd0);
    chk("stray_last_clr", 64'(ch_last_clr), 64'd0);
    @(posedge clk); #1;
    bus.output_buffer_we = 1'b0;
    bus.input_buffer_ready_clr = 1'b0;
    bus.last_block_in_buffer_clr = 1'b0;
    @(negedge clk);
    chk("cfg_en_off", 64'(bus.copy_control_regs_en), 64'd0);
    chk("obr_absorb", 64'(bus.output_buffer_ready), 64'd0);
    for (int b = 0; b < nblk; b++) begin
      last_b = (b == nblk - 1);
      if (last_b) ch_block_last[own] = 1'b1;
      #1;
      chk("ibr", 64'(bus.input_buffer_ready), 64'd1);
      chk("lbib", 64'(bus.last_block_in_buffer), 64'(last_b));
      bus.input_buffer_ready_clr = 1'b1;
      bus.last_block_in_buffer_clr = last_b;
      #1;
      chk("blk_clr", 64'(ch_block_clr), 64'(oh));
      chk("last_clr", 64'(ch_last_clr), last_b ? 64'(oh) : 64'd0);
      @(posedge clk); #1;
      bus.input_buffer_ready_clr = 1'b0;
      bus.last_block_in_buffer_clr = 1'b0;
      if (last_b) begin
        ch_block_valid[own] = 1'b0;
        ch_block_last[own] = 1'b0;
      end
      @(negedge clk);
    end
    want = exp_blocks(size_m[own], mode_m[own]);
    pulses = 0;
    cyc = 0;
    while (ch_grant === oh && cyc < 40) begin
      if (stall && cyc < 2) begin
        ch_out_ready[own] = 1'b0;
        #1;
        chk("obr_stall", 64'(bus.output_buffer_ready), 64'd0);
        chk("grant_hold", 64'(ch_grant), 64'(oh));
      end else begin
        #1;
        chk("obr", 64'(bus.output_buffer_ready), 64'd1);
        bus.output_buffer_we = 1'b1;
        #1;
        chk("out_we", 64'(ch_out_we), 64'(oh));
        pulses++;
      end
      @(posedge clk); #1;
      bus.output_buffer_we = 1'b0;
      ch_out_ready[own] = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk("we_count", 64'(pulses), 64'(want));
    chk("release_grant", 64'(ch_grant), 64'd0);
    chk("obr_idle", 64'(bus.output_buffer_ready), 64'd0);
    ptr_m = (own + 1) % NUM_CH;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    ch_rate_input = '0;
    ch_output_size = '0;
    ch_operation_mode = '0;
    ch_block_valid = '0;
    ch_block_last = '0;
    ch_out_ready = '1;
    bus.input_buffer_ready_clr = 1'b0;
    bus.last_block_in_buffer_clr = 1'b0;
    bus.output_buffer_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(ch_grant), 64'd0);
    chk("rst_cfg_en", 64'(bus.copy_control_regs_en), 64'd0);
    chk("rst_obr", 64'(bus.output_buffer_ready), 64'd0);
    chk("rst_ibr", 64'(bus.input_buffer_ready), 64'd0);
    chk("rst_size", 64'(bus.output_size), 64'd0);
    rst = 1'b0;

    req(0, 32'd256, 2'b00);
    req(1, 32'd512, 2'b01);
    serve(1, 1'b0);
    serve(1, 1'b0);

    req(0, 32'd256, 2'b00);
    serve(1, 1'b0);
    req(1, 32'd3000, 2'b00);
    serve(2, 1'b0);

    req(0, 32'd1088, 2'b01);
    serve(1, 1'b0);
    req(1, 32'd1089, 2'b01);
    serve(1, 1'b0);
    req(0, 32'd0, 2'b01);
    serve(1, 1'b0);

    req(1, 32'd2000, 2'b00);
    req(0, 32'd700, 2'b11);
    serve(1, 1'b1);
    serve(1, 1'b0);

    for (int r = 0; r < 24; r++) begin
      for (int c = 0; c < NUM_CH; c++)
        if (!ch_block_valid[c] && $urandom_range(0, 1) == 1) req_rand(c);
      if (ch_block_valid == '0) req_rand(int'($urandom_range(0, NUM_CH - 1)));
      serve(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < NUM_CH; k++)
      if (ch_block_valid != '0) serve(1, 1'b0);

    // Leave rr_ptr at 1 so a pointer surviving reset would favour ch1 afterwards.
    req(0, 32'd100, 2'b00);
    serve(1, 1'b0);
    req(1, 32'd5000, 2'b00);
    cyc = 0;
    while (ch_grant === '0 && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_grant", 64'(ch_grant), 64'd2);
    @(negedge clk);
    ch_block_last[1] = 1'b1;
    bus.input_buffer_ready_clr = 1'b1;
    bus.last_block_in_buffer_clr = 1'b1;
    @(posedge clk); #1;
    bus.input_buffer_ready_clr = 1'b0;
    bus.last_block_in_buffer_clr = 1'b0;
    ch_block_valid[1] = 1'b0;
    ch_block_last[1] = 1'b0;
    @(negedge clk);
    chk("abort_obr", 64'(bus.output_buffer_ready), 64'd1);
    bus.output_buffer_we = 1'b1;
    @(posedge clk); #1;
    bus.output_buffer_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_grant0", 64'(ch_grant), 64'd0);
    chk("abort_obr0", 64'(bus.output_buffer_ready), 64'd0);
    chk("abort_size0", 64'(bus.output_size), 64'd0);
    chk("abort_rate0", bus.rate_input[63:0], 64'd0);
    bus.output_buffer_we = 1'b1;
    #1;
    chk("abort_we0", 64'(ch_out_we), 64'd0);
    bus.output_buffer_we = 1'b0;
    ptr_m = 0;
    req(0, 32'd1344, 2'b00);
    req(1, 32'd1345, 2'b00);
    serve(1, 1'b0);
    serve(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
